// File: rtl/test_master_rw16.sv
// test_master_rw16
//   Single-outstanding Avalon-MM test master. A command is accepted in IDLE.
//   It is then issued as one read or write on the avm_test_* bus, and the
//   result is reported as a one-cycle rsp_valid pulse. All outputs are
//   registered.
//
// Ports
//   csi_MCLK_clk           clock; all logic is on the rising edge
//   rsi_MRST_reset         synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake; cmd_ready is high only in IDLE
//   cmd_write              1 = write, 0 = read
//   cmd_address[5:0]       target word address
//   cmd_writedata[15:0]    write data
//   cmd_byteenable[1:0]    byte lanes
//   rsp_valid              one-cycle pulse when a transfer finishes
//   rsp_readdata[15:0]     data from the last completed read
//   rsp_error              qualifies rsp_valid; 1 = timeout abort
//   avm_test_*             Avalon-MM master port
//
// Configuration
//   TEST_MASTER_TIMEOUT_EN  When defined, a transfer aborts after
//                           TIMEOUT_CYCLES stalled cycles. When undefined,
//                           the master waits indefinitely.
module test_master_rw16 #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [5:0]  cmd_address,
  input  logic [15:0] cmd_writedata,
  input  logic [1:0]  cmd_byteenable,
  output logic        rsp_valid,
  output logic [15:0] rsp_readdata,
  output logic        rsp_error,
  output logic [5:0]  avm_test_address,
  output logic [15:0] avm_test_writedata,
  output logic [1:0]  avm_test_byteenable,
  output logic        avm_test_write,
  output logic        avm_test_read,
  input  logic [15:0] avm_test_readdata,
  input  logic        avm_test_waitrequest
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_error_q, rsp_error_d;
  logic [15:0] rsp_rd_q, rsp_rd_d;
  logic [5:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;

`ifdef TEST_MASTER_TIMEOUT_EN
  // The abort fires on the stalled edge that would have taken the count
  // to TIMEOUT_CYCLES. As a result, the strobe is high for exactly
  // TIMEOUT_CYCLES stalled cycles.
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  cnt_q, cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = rsp_error_q;
    rsp_rd_d    = rsp_rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
`ifdef TEST_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_address;
          wdata_d     = cmd_writedata;
          be_d        = cmd_byteenable;
          rd_d        = ~cmd_write;
          wr_d        = cmd_write;
          cmd_ready_d = 1'b0;
          state_d     = cmd_write ? WRITE : READ;
`ifdef TEST_MASTER_TIMEOUT_EN
          cnt_d       = 8'd0;
`endif
        end
      end
      READ, WRITE: begin
        if (!avm_test_waitrequest) begin
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b0;
          state_d     = RESP;
          if (state_q == READ) rsp_rd_d = avm_test_readdata;
        end
`ifdef TEST_MASTER_TIMEOUT_EN
        else if (cnt_q == CntLast) begin
          // Abort: rsp_readdata is deliberately left untouched.
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d       = cnt_q + 8'd1;
        end
`endif
      end
      RESP: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        rsp_error_d = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rd_q    <= 16'd0;
      addr_q      <= 6'd0;
      wdata_q     <= 16'd0;
      be_q        <= 2'd0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
`ifdef TEST_MASTER_TIMEOUT_EN
      cnt_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rd_q    <= rsp_rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
`ifdef TEST_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign cmd_ready           = cmd_ready_q;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_error           = rsp_error_q;
  assign rsp_readdata        = rsp_rd_q;
  assign avm_test_address    = addr_q;
  assign avm_test_writedata  = wdata_q;
  assign avm_test_byteenable = be_q;
  assign avm_test_read       = rd_q;
  assign avm_test_write      = wr_q;

endmodule

// File: tb/tb_test_master_rw16.sv
// Testbench for test_master_rw16. The bench acts as an Avalon slave with a
// planned stall count per transfer. Every transfer is predicted from the
// command and the stall plan: strobe length, response, error flag and
// captured read data. The prediction is then compared with what the master
// does.
module tb_test_master_rw16;
  localparam int TO = 64;
`ifdef TEST_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [5:0]  cmd_address;
  logic [15:0] cmd_writedata;
  logic [1:0]  cmd_byteenable;
  logic        rsp_valid, rsp_error;
  logic [15:0] rsp_readdata;
  logic [5:0]  avm_test_address;
  logic [15:0] avm_test_writedata;
  logic [1:0]  avm_test_byteenable;
  logic        avm_test_write, avm_test_read;
  logic [15:0] avm_test_readdata;
  logic        avm_test_waitrequest;

  int n_cmp = 0;
  int n_bad = 0;
  int both_hi = 0;
  logic [15:0] last_rd;

  always #5 clk = ~clk;

  test_master_rw16 #(.TIMEOUT_CYCLES(TO)) dut (
    .csi_MCLK_clk(clk), .rsi_MRST_reset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .cmd_byteenable(cmd_byteenable),
    .rsp_valid(rsp_valid), .rsp_readdata(rsp_readdata), .rsp_error(rsp_error),
    .avm_test_address(avm_test_address), .avm_test_writedata(avm_test_writedata),
    .avm_test_byteenable(avm_test_byteenable), .avm_test_write(avm_test_write),
    .avm_test_read(avm_test_read), .avm_test_readdata(avm_test_readdata),
    .avm_test_waitrequest(avm_test_waitrequest)
  );

  always @(negedge clk) if (avm_test_read && avm_test_write) both_hi++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transfer. The slave stalls the first `stalls` strobe
  // cycles and returns sdata when it releases.
  task automatic run_txn(input bit wr, input logic [5:0] a, input logic [15:0] d,
                         input logic [1:0] be, input int stalls, input logic [15:0] sdata);
    int  k, bad, guard, exp_n;
    bit  exp_err;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_address = a;
    cmd_writedata = d; cmd_byteenable = be;
    @(negedge clk);
    // Scramble the command inputs to confirm the master latched them.
    cmd_valid = 1'b0; cmd_write = $urandom; cmd_address = 6'($urandom);
    cmd_writedata = 16'($urandom); cmd_byteenable = 2'($urandom);
    exp_err = TO_EN && (stalls >= TO);
    exp_n   = exp_err ? TO : stalls + 1;
    k = 0; bad = 0;
    while ((avm_test_read || avm_test_write) && k < 2000) begin
      if (avm_test_read !== !wr || avm_test_write !== wr ||
          avm_test_address !== a || avm_test_byteenable !== be ||
          (wr && avm_test_writedata !== d) ||
          cmd_ready !== 1'b0 || rsp_valid !== 1'b0) bad++;
      avm_test_waitrequest = (k < stalls);
      avm_test_readdata    = (k < stalls) ? 16'($urandom) : sdata;
      k++;
      @(negedge clk);
    end
    avm_test_waitrequest = 1'b0;
    chk("strobe_cycles", k, exp_n);
    chk("bus_stable", bad, 0);
    if (!wr && !exp_err) last_rd = sdata;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_error", rsp_error, exp_err);
    chk("rsp_readdata", rsp_readdata, last_rd);
    chk("ready_in_resp", cmd_ready, 0);
    @(negedge clk);
    chk("rsp_one_pulse", rsp_valid, 0);
    chk("ready_after_resp", cmd_ready, 1);
    chk("readdata_hold", rsp_readdata, last_rd);
  endtask

  initial begin
    int acc, rsps;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0;
    cmd_writedata = '0; cmd_byteenable = '0;
    avm_test_readdata = '0; avm_test_waitrequest = 1'b0;
    last_rd = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_avm", {avm_test_read, avm_test_write, avm_test_address,
                    avm_test_writedata, avm_test_byteenable}, 0);
    chk("rst_rsp", {rsp_valid, rsp_error, rsp_readdata}, 0);

    // Directed cases: zero-wait write, 30-stall read, byte-enable write/readback.
    run_txn(1'b1, 6'd0, 16'hA55A, 2'b11, 0, 16'h0000);
    run_txn(1'b0, 6'd1, 16'h0000, 2'b11, 30, 16'h1234);
    run_txn(1'b1, 6'd0, 16'hFF00, 2'b01, 0, 16'h0000);
    run_txn(1'b0, 6'd0, 16'h0000, 2'b11, 2, 16'h00AA);
    run_txn(1'b1, 6'd7, 16'h5555, 2'b00, 1, 16'h0000);

    // Randomized traffic, occasionally with long stalls.
    for (int i = 0; i < 24; i++) begin
      int st;
      st = ($urandom_range(0, 7) == 0) ? 30 : int'($urandom_range(0, 4));
      run_txn(1'($urandom), 6'($urandom), 16'($urandom), 2'($urandom), st, 16'($urandom));
    end

    // Stuck slave: abort with the timeout enabled, otherwise still waiting at cycle 1000.
    run_txn(1'b0, 6'd5, 16'h0000, 2'b11, 1000, 16'hBEEF);

    // Reset during cycle 3 of a stalled read.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 6'd9; cmd_byteenable = 2'b11;
    @(negedge clk);
    cmd_valid = 1'b0; avm_test_waitrequest = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("pre_reset_read_hi", avm_test_read, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_avm", {avm_test_read, avm_test_write, avm_test_address,
                        avm_test_writedata, avm_test_byteenable}, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_readdata", rsp_readdata, 0);
    last_rd = 16'd0;
    avm_test_waitrequest = 1'b0;
    rsps = 0;
    repeat (5) begin @(negedge clk); if (rsp_valid) rsps++; end
    chk("no_rsp_after_abort", rsps, 0);

    // cmd_valid held high: back-to-back zero-wait writes, one per 3 cycles.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 6'd3;
    cmd_writedata = 16'h0F0F; cmd_byteenable = 2'b10;
    acc = 0; rsps = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (cmd_ready) acc++;
      if (rsp_valid) rsps++;
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", acc, 10);
    chk("b2b_responses", rsps, 10);
    repeat (4) @(negedge clk);
    chk("b2b_readdata", rsp_readdata, last_rd);
    chk("never_both_strobes", both_hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
